// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, display enable, pixel
// coordinates and line/frame strobes, all decoded from next-state counters.
module vga_timing_gen #(
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;

    generate
        if (H_DISP == 0 || V_DISP == 0) begin : g_bad_disp
            $error("vga_timing_gen: H_DISP and V_DISP must be non-zero");
        end
        if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
            $error("vga_timing_gen: CW too narrow for the frame totals");
        end
    endgenerate

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    // Region bounds carry one spare bit so a display region ending exactly at 2^CW still decodes.
    localparam logic [CW:0] H_SE = (CW+1)'(H_SYNC);
    localparam logic [CW:0] H_VB = (CW+1)'(H_SYNC + H_BP);
    localparam logic [CW:0] H_VE = (CW+1)'(H_SYNC + H_BP + H_DISP);
    localparam logic [CW:0] V_SE = (CW+1)'(V_SYNC);
    localparam logic [CW:0] V_VB = (CW+1)'(V_SYNC + V_BP);
    localparam logic [CW:0] V_VE = (CW+1)'(V_SYNC + V_BP + V_DISP);

    localparam logic HP = H_POL[0];
    localparam logic VP = V_POL[0];

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_nxt, v_nxt;
    logic          adv, park;
    logic          h_vis, v_vis, hs_act, vs_act;

    always_comb begin
        adv   = ce & run;
        park  = ce & ~run;
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (park) begin
            h_nxt = H_LAST;
            v_nxt = V_LAST;
        end else if (adv) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
            end else begin
                h_nxt = h_cnt + ONE;
            end
        end
    end

    always_comb begin
        hs_act = {1'b0, h_nxt} < H_SE;
        vs_act = {1'b0, v_nxt} < V_SE;
        h_vis  = ({1'b0, h_nxt} >= H_VB) && ({1'b0, h_nxt} < H_VE);
        v_vis  = ({1'b0, v_nxt} >= V_VB) && ({1'b0, v_nxt} < V_VE);
    end

    // Outputs follow the position the counters move to on this edge, so no extra latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            hsync       <= ~HP;
            vsync       <= ~VP;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (park) begin
                hsync <= ~HP;
                vsync <= ~VP;
                de    <= 1'b0;
                pix_x <= '0;
                pix_y <= '0;
            end else if (adv) begin
                hsync       <= hs_act ? HP : ~HP;
                vsync       <= vs_act ? VP : ~VP;
                de          <= h_vis & v_vis;
                pix_x       <= h_vis ? h_nxt - H_VB[CW-1:0] : '0;
                pix_y       <= v_vis ? v_nxt - V_VB[CW-1:0] : '0;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 geometry and a tiny active-high
// geometry driven together, with a queued reference model checked every clock.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] px;
        logic [10:0] py;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n_d, rst_n_s, ce, run;

    logic        hs_d, vs_d, de_d, ls_d, fs_d;
    logic [10:0] px_d, py_d;
    logic        hs_s, vs_s, de_s, ls_s, fs_s;
    logic [10:0] px_s, py_s;

    obs_t out_d, out_s;
    assign out_d = {hs_d, vs_d, de_d, px_d, py_d, ls_d, fs_d};
    assign out_s = {hs_s, vs_s, de_s, px_s, py_s, ls_s, fs_s};

    always #5 clk = ~clk;

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(rst_n_d), .ce(ce), .run(run),
        .hsync(hs_d), .vsync(vs_d), .de(de_d), .pix_x(px_d), .pix_y(py_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(2), .H_DISP(4), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_DISP(3), .V_FP(1),
        .H_POL(1), .V_POL(1), .CW(11)
    ) u_small (
        .clk(clk), .rst_n(rst_n_s), .ce(ce), .run(run),
        .hsync(hs_s), .vsync(vs_s), .de(de_s), .pix_x(px_s), .pix_y(py_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    // Geometry per model slot: 0 = default instance, 1 = small instance.
    int g_hs[2]  = '{96, 2};
    int g_hbp[2] = '{48, 2};
    int g_hd[2]  = '{640, 4};
    int g_hfp[2] = '{16, 2};
    int g_vs[2]  = '{2, 1};
    int g_vbp[2] = '{33, 1};
    int g_vd[2]  = '{480, 3};
    int g_vfp[2] = '{10, 1};
    bit g_hp[2]  = '{1'b0, 1'b1};
    bit g_vp[2]  = '{1'b0, 1'b1};

    int   mh[2], mv[2];
    obs_t mlev[2];
    obs_t q_d[$];
    obs_t q_s[$];

    int tests = 0;
    int failed = 0;

    function automatic int htot(int d);
        return g_hs[d] + g_hbp[d] + g_hd[d] + g_hfp[d];
    endfunction

    function automatic int vtot(int d);
        return g_vs[d] + g_vbp[d] + g_vd[d] + g_vfp[d];
    endfunction

    function automatic obs_t idle_obs(int d);
        obs_t o;
        o    = '0;
        o.hs = !g_hp[d];
        o.vs = !g_vp[d];
        return o;
    endfunction

    function automatic obs_t decode(int d, int h, int v);
        obs_t o;
        int   hb, vb;
        bit   hv, vv;
        hb   = g_hs[d] + g_hbp[d];
        vb   = g_vs[d] + g_vbp[d];
        hv   = (h >= hb) && (h < hb + g_hd[d]);
        vv   = (v >= vb) && (v < vb + g_vd[d]);
        o    = '0;
        o.hs = (h < g_hs[d]) ? g_hp[d] : !g_hp[d];
        o.vs = (v < g_vs[d]) ? g_vp[d] : !g_vp[d];
        o.de = hv && vv;
        o.px = hv ? 11'(h - hb) : 11'd0;
        o.py = vv ? 11'(v - vb) : 11'd0;
        return o;
    endfunction

    task automatic model_reset(input int d);
        mh[d]   = htot(d) - 1;
        mv[d]   = vtot(d) - 1;
        mlev[d] = idle_obs(d);
    endtask

    task automatic push_exp(input int d, input obs_t e);
        if (d == 0) q_d.push_back(e);
        else        q_s.push_back(e);
    endtask

    task automatic check_pop(input int d, input string tag);
        obs_t e, a;
        tests++;
        if ((d == 0 && q_d.size() == 0) || (d == 1 && q_s.size() == 0)) begin
            failed++;
            $error("FAIL %s: scoreboard empty when output was due", tag);
        end else begin
            e = (d == 0) ? q_d.pop_front() : q_s.pop_front();
            a = (d == 0) ? out_d : out_s;
            assert (a === e) else begin
                failed++;
                $error("FAIL %s: observed %h expected %h (hs vs de px py ls fs)", tag, a, e);
            end
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock with the given controls, predict both instances, check after the edge.
    task automatic step(input logic ce_v, input logic run_v);
        obs_t e;
        ce  = ce_v;
        run = run_v;
        for (int d = 0; d < 2; d++) begin
            if (ce_v && run_v) begin
                mh[d]++;
                if (mh[d] == htot(d)) begin
                    mh[d] = 0;
                    mv[d]++;
                    if (mv[d] == vtot(d)) mv[d] = 0;
                end
                e    = decode(d, mh[d], mv[d]);
                e.ls = (mh[d] == 0);
                e.fs = (mh[d] == 0) && (mv[d] == 0);
            end else if (ce_v) begin
                model_reset(d);
                e = mlev[d];
            end else begin
                e    = mlev[d];
                e.ls = 1'b0;
                e.fs = 1'b0;
            end
            mlev[d] = e;
            push_exp(d, e);
        end
        @(posedge clk);
        #1;
        check_pop(0, "dflt_step");
        check_pop(1, "small_step");
    endtask

    initial begin
        int hs_low, vs_low, de_cnt, de_early, pxmax, ls_cnt, ls2_at, fs_cnt;
        int s_hs, s_vs, s_de, s_fs, s_ls;

        rst_n_d = 1'b0;
        rst_n_s = 1'b0;
        ce      = 1'b0;
        run     = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        push_exp(0, mlev[0]);
        push_exp(1, mlev[1]);
        check_pop(0, "dflt_reset");
        check_pop(1, "small_reset");
        rst_n_d = 1'b1;
        rst_n_s = 1'b1;

        // Default geometry: ce every clock through line 35, the first visible line.
        hs_low = 0; vs_low = 0; de_cnt = 0; de_early = 0;
        pxmax = 0; ls_cnt = 0; ls2_at = -1; fs_cnt = 0;
        for (int n = 0; n < 36 * 800; n++) begin
            step(1'b1, 1'b1);
            if (n == 0) begin
                cmp_int("first_fs", int'(out_d.fs), 1);
                cmp_int("first_ls", int'(out_d.ls), 1);
                cmp_int("first_hs", int'(out_d.hs), 0);
                cmp_int("first_vs", int'(out_d.vs), 0);
                cmp_int("first_de", int'(out_d.de), 0);
            end
            if (n == 1) cmp_int("fs_drop", int'(out_d.fs), 0);
            if (n < 800 && !out_d.hs) hs_low++;
            if (!out_d.vs) vs_low++;
            if (out_d.de) begin
                de_cnt++;
                if (n < 35 * 800) de_early++;
                if (int'(out_d.px) > pxmax) pxmax = int'(out_d.px);
            end
            if (out_d.ls) begin
                ls_cnt++;
                if (ls_cnt == 2) ls2_at = n;
            end
            if (out_d.fs) fs_cnt++;
        end
        cmp_int("hsync_low_ticks", hs_low, 96);
        cmp_int("vsync_low_ticks", vs_low, 1600);
        cmp_int("de_line35_ticks", de_cnt, 640);
        cmp_int("de_before_line35", de_early, 0);
        cmp_int("pix_x_max", pxmax, 639);
        cmp_int("pix_x_return", int'(out_d.px), 0);
        cmp_int("line_period", ls2_at, 800);
        cmp_int("line_start_count", ls_cnt, 36);
        cmp_int("frame_start_count", fs_cnt, 1);

        // Small geometry: park, then one full frame with ce every clock.
        step(1'b1, 1'b0);
        s_hs = 0; s_vs = 0; s_de = 0; s_fs = 0;
        for (int n = 0; n < 60; n++) begin
            step(1'b1, 1'b1);
            if (out_s.hs) s_hs++;
            if (out_s.vs) s_vs++;
            if (out_s.de) s_de++;
            if (out_s.fs) s_fs++;
        end
        cmp_int("small_hs_high", s_hs, 12);
        cmp_int("small_vs_high", s_vs, 10);
        cmp_int("small_de_high", s_de, 12);
        cmp_int("small_fs_count", s_fs, 1);

        // ce on every 4th clock: one small frame spans 240 clocks, strobes stay 1 clock wide.
        s_fs = 0; s_ls = 0;
        for (int n = 0; n < 60; n++) begin
            step(1'b1, 1'b1);
            if (out_s.fs) s_fs++;
            if (out_s.ls) s_ls++;
            repeat (3) begin
                step(1'b0, 1'b1);
                if (out_s.fs) s_fs++;
                if (out_s.ls) s_ls++;
            end
        end
        cmp_int("ce4_fs_clks", s_fs, 1);
        cmp_int("ce4_ls_clks", s_ls, 6);

        // Mid-frame run drop, five parked ticks, then a fresh frame.
        repeat (23) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        cmp_int("park_de", int'(out_s.de), 0);
        cmp_int("park_hs", int'(out_s.hs), 0);
        step(1'b1, 1'b1);
        cmp_int("restart_fs", int'(out_s.fs), 1);
        cmp_int("restart_hs", int'(out_s.hs), 1);

        // Asynchronous reset pulse in the middle of a line.
        repeat (13) step(1'b1, 1'b1);
        rst_n_s = 1'b0;
        #1;
        model_reset(1);
        push_exp(1, mlev[1]);
        check_pop(1, "small_async_reset");
        #1;
        rst_n_s = 1'b1;
        step(1'b1, 1'b1);
        cmp_int("post_reset_fs", int'(out_s.fs), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Produces horizontal and vertical sync, a display-enable signal, pixel coordinates and line/frame start strobes from a single clock gated by a pixel clock-enable.
- Successor to the single-axis horizontal sync counter. Adds a vertical axis, configurable geometry and sync polarity, reset, run control and coordinate outputs.
- Sits between the clock-enable divider and the pixel/frame-buffer readout logic feeding the DAC pins.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync active level
- CW, 11, counter and coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; the position advances only on clk edges where ce=1
- run  in  1  1 = generate timing; 0 = park at end of frame
- hsync  out  1  horizontal sync at H_POL level when active
- vsync  out  1  vertical sync at V_POL level when active
- de  out  1  display enable, active-high
- pix_x  out  CW  visible column 0..H_DISP-1, 0 outside the visible region
- pix_y  out  CW  visible row 0..V_DISP-1, 0 outside the visible region
- line_start  out  1  one-clk strobe when h_cnt becomes 0
- frame_start  out  1  one-clk strobe when (h_cnt, v_cnt) becomes (0, 0)

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_DISP+H_FP; V_TOTAL = V_SYNC+V_BP+V_DISP+V_FP.
- Segment order on each axis: sync, back porch, display, front porch. Position 0 is the first sync pixel or line.
- Internal registered counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
- Reset (async, rst_n=0):
  - h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - hsync=!H_POL, vsync=!V_POL, de=0, pix_x=0, pix_y=0, line_start=0, frame_start=0.
- Advance, on an edge with ce=1 and run=1:
  - h_cnt wraps H_TOTAL-1 -> 0, otherwise increments.
  - On an h wrap, v_cnt wraps V_TOTAL-1 -> 0, otherwise increments.
  - v_cnt changes only on an h wrap.
- The first ce tick after reset therefore lands on (0,0) and raises frame_start and line_start.
- All outputs are registered and decoded from the next-state counters on the same edge, so outputs always match the current position with zero added latency.
- Decode rules:
  - hsync active iff h_cnt < H_SYNC.
  - vsync active iff v_cnt < V_SYNC.
  - h_vis iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_DISP; v_vis is the same form on the vertical axis.
  - de = h_vis & v_vis.
  - pix_x = h_cnt-(H_SYNC+H_BP) when h_vis, else 0.
  - pix_y = v_cnt-(V_SYNC+V_BP) when v_vis, else 0.
  - Subtraction is CW-bit unsigned and never underflows inside the guarded range.
- Strobes: line_start and frame_start are high only in the single clk cycle after the advancing edge. They drop on the next clk edge even if ce=0.
- ce=0: counters and all level outputs hold; strobes clear.
- run=0, applied on a ce=1 edge:
  - Counters load (H_TOTAL-1, V_TOTAL-1); outputs go to their reset values.
  - When run returns to 1, the next ce tick starts a fresh frame at (0,0).
- Mid-frame run drop: takes effect on the next ce edge. No partial line completion.
- rst_n assertion mid-line: immediate asynchronous return to reset values. Deassertion is synchronised externally by the caller.
- Invalid parameters: H_DISP=0 or V_DISP=0 are illegal; flag with an elaboration-time error.

Test Plan:
- Reset, then ce=1 every clk with run=1 -> first clk after the tick: frame_start=1, line_start=1, hsync=0, vsync=0, de=0; frame_start=0 on the next clk.
- One full line, defaults -> hsync low exactly 96 ticks, de high 640 ticks only within lines 35..514, pix_x runs 0..639 and then returns to 0, line period 800 ticks.
- Full frame -> vsync low for 2 lines (1600 ticks), frame period 420000 ticks, pix_y 0..479, exactly one frame_start per frame.
- ce asserted every 4th clk -> all periods scale ×4, outputs stable between ticks, strobes exactly 1 clk wide.
- run=0 at h_cnt=300, v_cnt=100, then run=1 five ticks later -> outputs idle while parked, next tick gives frame_start with position (0,0).
- Small geometry H=2/2/4/2, V=1/1/3/1, H_POL=1, V_POL=1 -> hsync high 2 of 10 ticks, vsync high 1 of 6 lines; async rst_n pulse mid-line returns all outputs to their reset values immediately.
